// File: rtl/slc3_mem_pkg.sv
// Shared types and constants for the SLC-3 memory responder.
//   mem_state_t      : responder FSM state encoding
//   IO_ADDR_DEFAULT  : default address decoded as the I/O port
//   WORD_W           : datapath word width
//   addr_in_range()  : true when no address bit at or above aw is set
package slc3_mem_pkg;

  localparam int WORD_W = 16;

  localparam logic [WORD_W-1:0] IO_ADDR_DEFAULT = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  function automatic logic addr_in_range(input logic [WORD_W-1:0] addr, input int aw);
    return (addr >> aw) == '0;
  endfunction

endpackage

// File: rtl/slc3_sram.sv
// Single-port synchronous word RAM.
//   clk  : clock
//   en   : access enable; no effect when low
//   we   : 1 = write din to addr, 0 = read addr into dout
//   addr : word address
//   din  : write data
//   dout : registered read data, updated only on an enabled read
// Contents are not reset.
module slc3_sram
  import slc3_mem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] din,
  output logic [WORD_W-1:0] dout
);

  logic [WORD_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= din;
      end else begin
        dout <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/mem2io_responder.sv
// Memory-side responder for the SLC-3 MAR/MDR bus. Serves one read or write
// from on-chip RAM or the memory-mapped I/O port after a fixed number of wait
// states, then pulses mem_rdy for one cycle.
//   clk, reset : clock, synchronous active-high reset
//   mem_req    : request strobe, only looked at in IDLE
//   mem_we     : 1 = write, 0 = read
//   MAR, MDR   : request address and write data
//   MDR_In     : read data, valid the cycle after mem_rdy, held until next read
//   mem_rdy    : one-cycle completion pulse (high in RESP)
//   busy       : high whenever not in IDLE
//   SW         : switch inputs, read at IO_ADDR
//   HEX_OUT    : hex display register, written at IO_ADDR
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for mem_req; latches request and loads wait counter
// WAIT  | counting down wait states; bus inputs ignored
// RESP  | mem_rdy high; read data / write committed on the exiting edge
module mem2io_responder
  import slc3_mem_pkg::*;
#(
  parameter int                ADDR_W      = 10,
  parameter int                WAIT_STATES = 2,
  parameter logic [WORD_W-1:0] IO_ADDR     = IO_ADDR_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [WORD_W-1:0] MAR,
  input  logic [WORD_W-1:0] MDR,
  output logic [WORD_W-1:0] MDR_In,
  output logic              mem_rdy,
  output logic              busy,
  input  logic [WORD_W-1:0] SW,
  output logic [WORD_W-1:0] HEX_OUT
);

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_STATES);

  mem_state_t        state_q, state_d;
  logic [3:0]        cnt_q;
  logic [WORD_W-1:0] req_addr_q;
  logic [WORD_W-1:0] req_data_q;
  logic              req_we_q;

  logic              req_is_io;
  logic              req_in_range;
  logic              sram_en;
  logic              sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [WORD_W-1:0] sram_dout;
  logic [WORD_W-1:0] rd_data;

  assign req_is_io    = (req_addr_q == IO_ADDR);
  assign req_in_range = addr_in_range(req_addr_q, ADDR_W);

  assign mem_rdy = (state_q == RESP);
  assign busy    = (state_q != IDLE);

  // The RAM read must happen on the edge entering RESP so dout is valid
  // during RESP. With zero wait states that edge is the accepting edge, so
  // the address comes straight from MAR while still in IDLE.
  always_comb begin
    state_d   = state_q;
    sram_en   = 1'b0;
    sram_we   = 1'b0;
    sram_addr = (state_q == IDLE) ? MAR[ADDR_W-1:0] : req_addr_q[ADDR_W-1:0];
    case (state_q)
      IDLE: begin
        if (mem_req) begin
          if (WAIT_STATES == 0) begin
            state_d = RESP;
            sram_en = !mem_we;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          sram_en = !req_we_q;
        end
      end
      RESP: begin
        state_d = IDLE;
        if (req_we_q && req_in_range) begin
          sram_en = 1'b1;
          sram_we = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A reset edge must not commit an in-flight write.
    if (reset) begin
      sram_en = 1'b0;
      sram_we = 1'b0;
    end
  end

  always_comb begin
    rd_data = '0;
    if (req_is_io) begin
      rd_data = SW;
    end else if (req_in_range) begin
      rd_data = sram_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      req_addr_q <= '0;
      req_data_q <= '0;
      req_we_q   <= 1'b0;
      MDR_In     <= '0;
      HEX_OUT    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (mem_req) begin
            req_addr_q <= MAR;
            req_data_q <= MDR;
            req_we_q   <= mem_we;
            cnt_q      <= CNT_LOAD;
          end
        end
        WAIT: cnt_q <= cnt_q - 4'd1;
        RESP: begin
          if (!req_we_q) begin
            MDR_In <= rd_data;
          end else if (req_is_io) begin
            HEX_OUT <= req_data_q;
          end
        end
        default: ;
      endcase
    end
  end

  slc3_sram #(
    .ADDR_W(ADDR_W)
  ) u_sram (
    .clk (clk),
    .en  (sram_en),
    .we  (sram_we),
    .addr(sram_addr),
    .din (req_data_q),
    .dout(sram_dout)
  );

endmodule

// File: tb/tb_mem2io_responder.sv
module tb_mem2io_responder;

  localparam int WS = 2;

  logic        clk;
  logic        reset;
  logic        mem_req, mem_we;
  logic [15:0] MAR, MDR, SW;
  logic [15:0] MDR_In, HEX_OUT;
  logic        mem_rdy, busy;

  logic        req0, we0;
  logic [15:0] mar0, mdr0, sw0;
  logic [15:0] mdr_in0, hex0;
  logic        rdy0, busy0;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] mdr;
    logic [15:0] hex;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] sw;
    logic [15:0] exp_mdr;
    logic [15:0] exp_hex;
  } vec_t;
  vec_t vecs[18];

  mem2io_responder #(.ADDR_W(10), .WAIT_STATES(WS), .IO_ADDR(16'hFFFF)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
    .MAR(MAR), .MDR(MDR), .MDR_In(MDR_In), .mem_rdy(mem_rdy), .busy(busy),
    .SW(SW), .HEX_OUT(HEX_OUT)
  );

  mem2io_responder #(.ADDR_W(10), .WAIT_STATES(0), .IO_ADDR(16'hFFFF)) dut0 (
    .clk(clk), .reset(reset), .mem_req(req0), .mem_we(we0),
    .MAR(mar0), .MDR(mdr0), .MDR_In(mdr_in0), .mem_rdy(rdy0), .busy(busy0),
    .SW(sw0), .HEX_OUT(hex0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Scoreboard: pops one expectation on the cycle after each mem_rdy pulse.
  initial begin : monitor
    exp_t e;
    logic rdy_prev;
    rdy_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rdy_prev) begin
        check("rdy_single_cycle", 16'(mem_rdy), 16'd0);
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_rdy actual=response required=none");
        end else begin
          e = sb_q.pop_front();
          check("mdr_in", MDR_In, e.mdr);
          check("hex_out", HEX_OUT, e.hex);
        end
      end
      rdy_prev = mem_rdy;
    end
  end

  task automatic do_req(input logic we, input logic [15:0] addr, input logic [15:0] data,
                        input logic [15:0] sw_v, input logic [15:0] exp_mdr,
                        input logic [15:0] exp_hex);
    int n;
    @(negedge clk);
    SW = sw_v; mem_req = 1'b1; mem_we = we; MAR = addr; MDR = data;
    sb_q.push_back('{exp_mdr, exp_hex});
    @(negedge clk);
    mem_req = 1'b0;
    n = 0;
    while (!mem_rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("latency", 16'(n), 16'(WS));
  endtask

  initial begin : main
    int first, second;
    logic [3:0] pat;

    vecs[0]  = '{1'b1, 16'h0005, 16'hBEEF, 16'h0000, 16'h0000, 16'h0000};
    vecs[1]  = '{1'b0, 16'h0005, 16'h0000, 16'h0000, 16'hBEEF, 16'h0000};
    vecs[2]  = '{1'b1, 16'h0006, 16'h6666, 16'h0000, 16'hBEEF, 16'h0000};
    vecs[3]  = '{1'b0, 16'hFFFF, 16'h0000, 16'h1234, 16'h1234, 16'h0000};
    vecs[4]  = '{1'b1, 16'hFFFF, 16'h00A5, 16'h1234, 16'h1234, 16'h00A5};
    vecs[5]  = '{1'b1, 16'h0000, 16'hCAFE, 16'h1234, 16'h1234, 16'h00A5};
    vecs[6]  = '{1'b0, 16'h0400, 16'h0000, 16'h1234, 16'h0000, 16'h00A5};
    vecs[7]  = '{1'b1, 16'h0400, 16'hFFFF, 16'h1234, 16'h0000, 16'h00A5};
    vecs[8]  = '{1'b0, 16'h0000, 16'h0000, 16'h1234, 16'hCAFE, 16'h00A5};
    vecs[9]  = '{1'b1, 16'h8005, 16'h1111, 16'h1234, 16'hCAFE, 16'h00A5};
    vecs[10] = '{1'b0, 16'h0005, 16'h0000, 16'h1234, 16'hBEEF, 16'h00A5};
    vecs[11] = '{1'b0, 16'h8005, 16'h0000, 16'h1234, 16'h0000, 16'h00A5};
    vecs[12] = '{1'b1, 16'h03FF, 16'h1357, 16'h1234, 16'h0000, 16'h00A5};
    vecs[13] = '{1'b0, 16'h03FF, 16'h0000, 16'h1234, 16'h1357, 16'h00A5};
    vecs[14] = '{1'b1, 16'h0007, 16'hAAAA, 16'h1234, 16'h1357, 16'h00A5};
    vecs[15] = '{1'b0, 16'h0007, 16'h0000, 16'h1234, 16'hAAAA, 16'h00A5};
    vecs[16] = '{1'b0, 16'h0006, 16'h0000, 16'h1234, 16'h6666, 16'h00A5};
    vecs[17] = '{1'b0, 16'hFFFE, 16'h0000, 16'h1234, 16'h0000, 16'h00A5};

    reset = 1'b1; mem_req = 1'b0; mem_we = 1'b0; MAR = '0; MDR = '0; SW = '0;
    req0 = 1'b0; we0 = 1'b0; mar0 = '0; mdr0 = '0; sw0 = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_rdy", 16'(mem_rdy), 16'd0);
    check("rst_mdr_in", MDR_In, 16'h0000);
    check("rst_hex", HEX_OUT, 16'h0000);
    reset = 1'b0;

    foreach (vecs[i])
      do_req(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].sw,
             vecs[i].exp_mdr, vecs[i].exp_hex);

    // Inputs changed during WAIT are ignored; held mem_req is taken on the
    // first IDLE cycle, giving pulses WS+2 apart.
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b0; MAR = 16'h0005; MDR = 16'h9999;
    sb_q.push_back('{16'hBEEF, 16'h00A5});
    sb_q.push_back('{16'h6666, 16'h00A5});
    @(negedge clk);
    MAR = 16'h0006;
    first = -1; second = -1;
    for (int i = 0; i < 16; i++) begin
      if (mem_rdy) begin
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
      if (first >= 0 && i == first + 1) check("gap_busy", 16'(busy), 16'd0);
      if (first >= 0 && i == first + 2) mem_req = 1'b0;
      @(negedge clk);
    end
    check("first_rdy_pos", 16'(first), 16'(WS));
    check("rdy_spacing", 16'(second - first), 16'(WS + 2));

    // SW is sampled in RESP, not at acceptance.
    @(negedge clk);
    SW = 16'h1111; mem_req = 1'b1; mem_we = 1'b0; MAR = 16'hFFFF;
    sb_q.push_back('{16'h5678, 16'h00A5});
    @(negedge clk);
    mem_req = 1'b0; SW = 16'h5678;
    repeat (4) @(negedge clk);

    // Reset during WAIT of a write drops it.
    mem_req = 1'b1; mem_we = 1'b1; MAR = 16'h0007; MDR = 16'h5555;
    @(negedge clk);
    mem_req = 1'b0; reset = 1'b1;
    @(negedge clk);
    check("midrst_busy", 16'(busy), 16'd0);
    check("midrst_rdy", 16'(mem_rdy), 16'd0);
    check("midrst_hex", HEX_OUT, 16'h0000);
    check("midrst_mdr_in", MDR_In, 16'h0000);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("post_rst_busy", 16'(busy), 16'd0);
    do_req(1'b0, 16'h0007, 16'h0000, 16'h0000, 16'hAAAA, 16'h0000);

    // Zero wait states: IDLE -> RESP directly.
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; mar0 = 16'h0003; mdr0 = 16'h0DD0;
    @(negedge clk);
    req0 = 1'b0;
    check("ws0_wr_rdy", 16'(rdy0), 16'd1);
    check("ws0_wr_busy", 16'(busy0), 16'd1);
    @(negedge clk);
    check("ws0_wr_rdy_off", 16'(rdy0), 16'd0);
    check("ws0_wr_idle", 16'(busy0), 16'd0);
    req0 = 1'b1; we0 = 1'b0;
    @(negedge clk);
    req0 = 1'b0;
    check("ws0_rd_rdy", 16'(rdy0), 16'd1);
    @(negedge clk);
    check("ws0_rd_data", mdr_in0, 16'h0DD0);
    mar0 = 16'hFFFF; sw0 = 16'h4242; req0 = 1'b1;
    pat = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pat = {pat[2:0], rdy0};
      if (i == 2) req0 = 1'b0;
    end
    check("ws0_held_req_pattern", 16'(pat), 16'b1010);
    check("ws0_io_read", mdr_in0, 16'h4242);

    repeat (3) @(negedge clk);
    check("sb_empty", 16'(sb_q.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem2io_responder.md
Name: mem2io_responder

Overview:
Memory-side responder for the SLC-3 datapath's MAR/MDR bus.
- The datapath issues a read or write request with MAR as the address and MDR as the write data.
- This block serves the request from on-chip word RAM or a memory-mapped I/O register after a fixed number of wait states.
- It then returns read data on the MDR_In path and pulses a ready strobe that the control FSM waits on.

Parameters:
- ADDR_W, 10: RAM address width; RAM depth is 2^ADDR_W 16-bit words.
- WAIT_STATES, 2: cycles spent in WAIT between request acceptance and response; legal range 0..15.
- IO_ADDR, 16'hFFFF: address decoded as the I/O port (switches on read, hex register on write).

Ports:
- clk, input, 1: system clock; all state changes on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- mem_req, input, 1: request strobe from control; sampled only in IDLE.
- mem_we, input, 1: 1 = write, 0 = read; qualified by mem_req.
- MAR, input, 16: request address.
- MDR, input, 16: write data.
- MDR_In, output, 16: read data to the datapath MDR mux.
- mem_rdy, output, 1: one-cycle completion pulse.
- busy, output, 1: high whenever state is not IDLE.
- SW, input, 16: switch inputs, read at IO_ADDR.
- HEX_OUT, output, 16: hex display register, written at IO_ADDR.

Behaviour:
- Reset, synchronous and active-high, applied on any cycle including mid-transaction:
  - state returns to IDLE.
  - MDR_In, HEX_OUT and the wait counter go to 0; mem_rdy and busy go to 0.
  - RAM contents are not cleared.
  - An in-flight write is dropped.
- States: IDLE, WAIT, RESP.
- IDLE:
  - If mem_req = 1, latch MAR, MDR and mem_we into request registers.
  - Load the counter with WAIT_STATES.
  - Go to WAIT, or straight to RESP when WAIT_STATES = 0.
  - If mem_req = 0, stay in IDLE.
- WAIT:
  - Decrement the counter each cycle; go to RESP when the counter reaches 1.
  - WAIT therefore lasts exactly WAIT_STATES cycles.
  - mem_req, MAR and MDR are ignored; changes to them have no effect on the in-flight request.
- RESP, one cycle, then unconditionally back to IDLE:
  - mem_rdy = 1.
  - Read to IO_ADDR: MDR_In takes the SW value sampled in this cycle.
  - Read to a RAM address: MDR_In takes RAM[addr[ADDR_W-1:0]].
  - Read to an address other than IO_ADDR with any bit above ADDR_W set (out of range): MDR_In = 16'h0000.
  - Write to IO_ADDR: HEX_OUT is updated.
  - Write to an in-range address: the RAM word is updated.
  - Write out of range: discarded silently.
  - MDR_In and HEX_OUT update on the edge that ends RESP, so both are valid in the first cycle after the mem_rdy cycle.
  - MDR_In holds its value until the next read completes; writes never change MDR_In.
- Latency: request accepted at edge N; mem_rdy high during cycle N+WAIT_STATES+1; MDR_In valid from the following cycle.
- Back-to-back: mem_req held high through RESP is not accepted in RESP. It is accepted on the first IDLE cycle, so the minimum spacing between acceptances is WAIT_STATES+2 cycles.
- mem_rdy is never high in two consecutive cycles.
- busy = (state != IDLE).
- A read after a write to the same address returns the new data.
- RAM is a single-port array, read and written only in RESP, so there are no read/write collisions.

Decomposition:
- Package slc3_mem_pkg:
  - state enum mem_state_t {IDLE, WAIT, RESP}.
  - constant IO_ADDR_DEFAULT = 16'hFFFF.
  - width constant WORD_W = 16.
- Sub-module slc3_sram: single-port synchronous 16-bit RAM with en, we, addr and din inputs and a registered dout output.
  - The responder keeps the FSM, counter, address decode and I/O register.
  - RAM dout feeds the MDR_In register in RESP. slc3_sram is therefore read at the edge entering RESP, so that dout is valid during RESP; this schedule is required.

Test Plan:
- Write then read, WAIT_STATES=2: write MAR=16'h0005, MDR=16'hBEEF; mem_rdy pulses 3 cycles after acceptance. Then read 16'h0005 -> MDR_In = 16'hBEEF the cycle after mem_rdy.
- I/O: SW=16'h1234, read 16'hFFFF -> MDR_In = 16'h1234. Write 16'hFFFF with MDR=16'h00A5 -> HEX_OUT = 16'h00A5; MDR_In unchanged at 16'h1234.
- Out of range (ADDR_W=10): read 16'h0400 -> MDR_In = 16'h0000. Write 16'h0400 with 16'hFFFF, then read 16'h0000 -> previous contents unchanged.
- Ignored inputs: accept a read of 16'h0005, then drive MAR=16'h0006 and mem_req=1 during WAIT. The response returns RAM[5], and exactly one mem_rdy is seen. A held mem_req is accepted on the next IDLE cycle; mem_rdy pulses are 4 cycles apart.
- Reset mid-operation: assert reset during WAIT of a write to 16'h0007 with 16'h5555. busy=0, mem_rdy=0 and HEX_OUT=0 the next cycle; a later read of 16'h0007 returns the old value.
- WAIT_STATES=0: request accepted at edge N -> mem_rdy high in cycle N+1, and WAIT is never entered.
